// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB-first with one full-subtractor
// cell and a borrow flip-flop, streaming each bit and then holding the parallel result.
module serial_subtractor #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             diff_bit,
  output logic             diff_bit_valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done_valid,
  input  logic             done_ready
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sa, sb, result;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             d, nb, last_bit;

  // Full-subtractor cell on the current LSBs.
  assign d        = sa[0] ^ sb[0] ^ borrow;
  assign nb       = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output and next-state signal gets a default first so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_next     = state;
    start_ready    = 1'b0;
    busy           = 1'b0;
    diff_bit       = 1'b0;
    diff_bit_valid = 1'b0;
    done_valid     = 1'b0;
    unique case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_next = SHIFT;
      end
      SHIFT: begin
        busy           = 1'b1;
        diff_bit       = d;
        diff_bit_valid = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done_valid = 1'b1;
        if (done_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      result <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (state == IDLE && start_valid) begin
      sa     <= a;
      sb     <= b;
      borrow <= bin;
      result <= '0;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      result <= {d, result[WIDTH-1:1]};
      borrow <= nb;
      cnt    <= cnt + 1'b1;
    end
  end

  // Result and borrow stay put outside SHIFT, so they hold through DONE and beyond.
  assign diff = result;
  assign bout = borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: a cycle model of the 8-bit block compared every cycle,
// directed vectors with literal expectations, and an exhaustive 4-bit sweep.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       sv8 = 0, dr8 = 1, bin8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic       start_ready8, busy8, diff_bit8, diff_bit_valid8, bout8, done_valid8;
  logic [7:0] diff8;

  // 4-bit instance
  logic       sv4 = 0, dr4 = 1, bin4 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic       start_ready4, busy4, diff_bit4, diff_bit_valid4, bout4, done_valid4;
  logic [3:0] diff4;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(start_ready8),
    .a(a8), .b(b8), .bin(bin8), .busy(busy8), .diff_bit(diff_bit8),
    .diff_bit_valid(diff_bit_valid8), .diff(diff8), .bout(bout8),
    .done_valid(done_valid8), .done_ready(dr8)
  );

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(start_ready4),
    .a(a4), .b(b4), .bin(bin4), .busy(busy4), .diff_bit(diff_bit4),
    .diff_bit_valid(diff_bit_valid4), .diff(diff4), .bout(bout4),
    .done_valid(done_valid4), .done_ready(dr4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the 8-bit instance: phase 0 idle, 1 streaming bit m_k, 2 holding result.
  int         m_phase = 0;
  int         m_k = 0;
  logic [7:0] m_ref = 0;
  logic       m_bout = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_k     <= 0;
    end else begin
      case (m_phase)
        0: if (sv8) begin
          m_ref   <= 8'((int'(a8) - int'(b8) - int'(bin8)) & 255);
          m_bout  <= (int'(a8) < int'(b8) + int'(bin8));
          m_k     <= 0;
          m_phase <= 1;
        end
        1: if (m_k == 7) m_phase <= 2;
           else          m_k <= m_k + 1;
        default: if (dr8) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("start_ready", 32'(start_ready8), 32'(m_phase == 0));
      check("busy", 32'(busy8), 32'(m_phase != 0));
      check("diff_bit_valid", 32'(diff_bit_valid8), 32'(m_phase == 1));
      check("done_valid", 32'(done_valid8), 32'(m_phase == 2));
      if (m_phase == 1) check("diff_bit", 32'(diff_bit8), 32'(m_ref[m_k]));
      if (m_phase == 2) begin
        check("diff", 32'(diff8), 32'(m_ref));
        check("bout", 32'(bout8), 32'(m_bout));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, " start_ready"}, 32'(start_ready8), 1);
    check({tag, " busy"}, 32'(busy8), 0);
    check({tag, " diff_bit"}, 32'(diff_bit8), 0);
    check({tag, " diff_bit_valid"}, 32'(diff_bit_valid8), 0);
    check({tag, " diff"}, 32'(diff8), 0);
    check({tag, " bout"}, 32'(bout8), 0);
    check({tag, " done_valid"}, 32'(done_valid8), 0);
  endtask

  // One 8-bit operation. inject>0: raise a bogus start at that streaming cycle.
  // abort_at>0: assert reset at that streaming cycle and return.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input int hold, input int inject, input int abort_at,
                      input logic [7:0] exp_diff, input logic exp_bout);
    logic [7:0] bits;
    logic       got;
    int         n;
    @(negedge clk);
    check("issue start_ready", 32'(start_ready8), 1);
    sv8 = 1; a8 = a; b8 = b; bin8 = bi;
    @(negedge clk);
    sv8 = 0; a8 = ~a; b8 = ~b; bin8 = ~bi;
    bits = '0; got = 0; n = 1;
    while (n <= 20 && !got) begin
      if (diff_bit_valid8) bits = {diff_bit8, bits[7:1]};
      if (inject > 0 && n == inject) begin
        sv8 = 1; a8 = 8'h11; b8 = 8'h22; bin8 = 0;
      end
      if (inject > 0 && n == inject + 2) sv8 = 0;
      if (abort_at > 0 && n == abort_at) begin
        rst_n = 0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1;
        return;
      end
      if (done_valid8) got = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("done seen", 32'(got), 1);
    if (got) begin
      check("latency", 32'(n), 9);
      check("serial bits", 32'(bits), 32'(exp_diff));
      check("literal diff", 32'(diff8), 32'(exp_diff));
      check("literal bout", 32'(bout8), 32'(exp_bout));
      if (hold > 0) begin
        dr8 = 0;
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          check("hold done_valid", 32'(done_valid8), 1);
          check("hold diff", 32'(diff8), 32'(exp_diff));
          check("hold bout", 32'(bout8), 32'(exp_bout));
          check("hold start_ready", 32'(start_ready8), 0);
        end
        dr8 = 1;
      end
      @(negedge clk);
      check("released start_ready", 32'(start_ready8), 1);
      check("released done_valid", 32'(done_valid8), 0);
    end
  endtask

  task automatic sweep4();
    logic       got;
    logic [3:0] e_diff;
    logic       e_bout;
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++) begin
          e_diff = 4'((ai - bi - ci) & 15);
          e_bout = (ai < bi + ci);
          @(negedge clk);
          check("sweep start_ready", 32'(start_ready4), 1);
          sv4 = 1; a4 = 4'(ai); b4 = 4'(bi); bin4 = ci[0];
          @(negedge clk);
          // start stays high with other operands while busy; must be ignored
          a4 = ~a4; b4 = ~b4; bin4 = ~bin4;
          got = 0;
          for (int n = 0; n < 12 && !got; n++) begin
            if (done_valid4) got = 1;
            else begin
              check("sweep busy start_ready", 32'(start_ready4), 0);
              @(negedge clk);
            end
          end
          sv4 = 0;
          check("sweep done seen", 32'(got), 1);
          check("sweep diff", 32'(diff4), 32'(e_diff));
          check("sweep bout", 32'(bout4), 32'(e_bout));
        end
  endtask

  initial begin
    #1;
    check_reset_outputs("reset");
    check("reset start_ready4", 32'(start_ready4), 1);
    @(negedge clk);
    rst_n = 1;

    run8(8'h5A, 8'h3C, 1'b0, 0, 0, 0, 8'h1E, 1'b0);
    run8(8'h00, 8'h01, 1'b0, 0, 0, 0, 8'hFF, 1'b1);
    run8(8'h80, 8'h7F, 1'b1, 0, 0, 0, 8'h00, 1'b0);
    run8(8'hFF, 8'hFF, 1'b1, 0, 0, 0, 8'hFF, 1'b1);
    run8(8'h5A, 8'h3C, 1'b0, 5, 0, 0, 8'h1E, 1'b0);
    run8(8'h5A, 8'h3C, 1'b0, 0, 3, 0, 8'h1E, 1'b0);
    run8(8'h11, 8'h22, 1'b0, 0, 0, 0, 8'hEF, 1'b1);
    run8(8'h5A, 8'h3C, 1'b0, 0, 0, 4, 8'h00, 1'b0);
    run8(8'h10, 8'h01, 1'b0, 0, 0, 0, 8'h0F, 1'b0);

    sweep4();

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
